// File: rtl/rgmii_rx_inband_status_decoder.sv
// -----------------------------------------------------------------------------
// rgmii_rx_inband_status_decoder
//
// Decodes the RGMII in-band status (link / speed / duplex) that a PHY drives
// on RXD during inter-frame gaps. The decoded status is debounced and then
// published as a committed status word. Runs in the RGMII RX clock domain,
// directly after the IDDR stage.
//
// A status sample is taken only when RX_CTL shows no frame, error or carrier
// extension. It must also show identical rising and falling nibbles and a
// non-reserved speed code. filter_p consecutive identical samples commit a
// status. timeout_p cycles without any valid sample invalidate the status.
//
// Ports:
//   clk_i          RGMII RX clock (SDR side of the IDDR)
//   reset_n_i      asynchronous active-low reset
//   rx_data_i[7:0] IDDR output, [3:0] rising nibble, [7:4] falling nibble
//   rx_dv_i        RX_CTL rising-edge sample (data valid)
//   rx_er_i        RX_CTL falling XOR rising sample (error / carrier ext.)
//   link_up_o      committed link status
//   speed_o[1:0]   committed speed, 00=10M 01=100M 10=1000M (same code as
//                  the TX clock generator speed select)
//   full_duplex_o  committed duplex
//   status_v_o     committed status is valid
//   change_v_o     one-cycle pulse when committed status or status_v_o changes
// -----------------------------------------------------------------------------
module rgmii_rx_inband_status_decoder #(
  parameter int filter_p  = 4,
  parameter int timeout_p = 65535
) (
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic [7:0] rx_data_i,
  input  logic       rx_dv_i,
  input  logic       rx_er_i,
  output logic       link_up_o,
  output logic [1:0] speed_o,
  output logic       full_duplex_o,
  output logic       status_v_o,
  output logic       change_v_o
);

  localparam int CNT_W  = $clog2(filter_p + 1);
  localparam int IDLE_W = $clog2(timeout_p + 1);

  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(filter_p);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(timeout_p);
  localparam logic [IDLE_W-1:0] IDLE_PRE = IDLE_W'(timeout_p - 1);
  localparam logic [IDLE_W-1:0] IDLE_ONE = IDLE_W'(1);

  typedef enum logic {
    UNKNOWN = 1'b0,
    STABLE  = 1'b1
  } state_t;

  state_t            state_r;
  state_t            state_nxt;
  logic [3:0]        cand_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [IDLE_W-1:0] idle_r;
  logic              link_r;
  logic [1:0]        speed_r;
  logic              duplex_r;
  logic              change_r;

  // Saturating increment of the filter count.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (c >= CNT_MAX) return CNT_MAX;
    return c + CNT_ONE;
  endfunction

  // Sample classification
  logic             status_cyc;
  logic             valid_s;
  logic [3:0]       sample;
  logic [CNT_W-1:0] cnt_upd;
  logic             commit;
  logic             timeout_hit;
  logic             differs;

  assign status_cyc  = ~rx_dv_i & ~rx_er_i;
  assign sample      = rx_data_i[3:0];
  assign valid_s     = status_cyc
                     & (rx_data_i[3:0] == rx_data_i[7:4])
                     & (rx_data_i[2:1] != 2'b11);
  assign cnt_upd     = (sample == cand_r) ? sat_inc(cnt_r) : CNT_ONE;
  assign commit      = valid_s & (cnt_upd == CNT_MAX);
  // Fires only on the cycle idle_r steps onto timeout_p, so a saturated
  // idle counter never re-triggers. A valid sample in that cycle wins.
  assign timeout_hit = ~valid_s & (idle_r == IDLE_PRE);
  assign differs     = (sample != {duplex_r, speed_r, link_r});

  // State register
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_r <= UNKNOWN;
    else            state_r <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state_r;
    if (commit)           state_nxt = STABLE;
    else if (timeout_hit) state_nxt = UNKNOWN;
  end

  // Filter, idle counter and committed status word
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cand_r   <= '0;
      cnt_r    <= '0;
      idle_r   <= '0;
      link_r   <= 1'b0;
      speed_r  <= 2'b00;
      duplex_r <= 1'b0;
      change_r <= 1'b0;
    end else begin
      if (valid_s) begin
        cand_r <= sample;
        cnt_r  <= cnt_upd;
      end else if (timeout_hit || status_cyc) begin
        // Invalid status cycles and the timeout restart the filter; frame
        // cycles leave it untouched.
        cnt_r <= '0;
      end

      if (valid_s)                idle_r <= '0;
      else if (idle_r != IDLE_MAX) idle_r <= idle_r + IDLE_ONE;

      if (commit) begin
        link_r   <= sample[0];
        speed_r  <= sample[2:1];
        duplex_r <= sample[3];
      end else if (timeout_hit) begin
        // Speed and duplex keep their last values for the TX side.
        link_r <= 1'b0;
      end

      change_r <= (commit && (state_r == UNKNOWN || differs))
               || (timeout_hit && state_r == STABLE);
    end
  end

  // Output logic
  always_comb begin
    link_up_o     = link_r;
    speed_o       = speed_r;
    full_duplex_o = duplex_r;
    status_v_o    = (state_r == STABLE);
    change_v_o    = change_r;
  end

endmodule
